// File: rtl/dds_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dds_sweep_ctrl
//  Description : Sequencer for a DDS slave core. It accepts one sweep job
//                through a valid/ready handshake. It applies the base tuning
//                word either at once or on the next phase-accumulator wrap.
//                It can pulse the core reset on apply. It then ramps
//                freq_add by a signed, saturating step every (dwell+1)
//                clocks for nsteps steps and pulses done when the job ends.
//  Ports       : clk, reset_n (async active-low)
//                cfg_valid/cfg_ready       config handshake (ready in IDLE)
//                cfg_freq/step/nsteps/dwell/sync/rst  job description
//                abort                     cancel the job, back to IDLE
//                phase                     DDS phase accumulator
//                freq, freq_add            tuning outputs to the DDS core
//                core_reset                one-cycle reset pulse to the core
//                busy, done                status (done is a one-cycle pulse)
//  Revision    : 1.0  initial release
// ============================================================================
module dds_sweep_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [31:0]      cfg_freq,
    input  logic [31:0]      cfg_step,
    input  logic [CNT_W-1:0] cfg_nsteps,
    input  logic [CNT_W-1:0] cfg_dwell,
    input  logic             cfg_sync,
    input  logic             cfg_rst,
    input  logic             abort,
    input  logic [31:0]      phase,
    output logic [31:0]      freq,
    output logic [31:0]      freq_add,
    output logic             core_reset,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_ARMED = 2'd1;
    localparam logic [1:0] c_S_RAMP  = 2'd2;
    localparam logic [1:0] c_S_DONE  = 2'd3;

    localparam logic [CNT_W-1:0] c_CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;

    // Shadow copy of the accepted job
    logic [31:0]      r_sh_freq;
    logic [31:0]      r_sh_step;
    logic [CNT_W-1:0] r_sh_nsteps;
    logic [CNT_W-1:0] r_sh_dwell;
    logic             r_sh_sync;
    logic             r_sh_rst;

    logic [31:0]      r_phase_d;
    logic [31:0]      r_freq;
    logic [31:0]      r_freq_add;
    logic             r_core_reset;
    logic             r_done;
    logic [CNT_W-1:0] r_steps_left;
    logic [CNT_W-1:0] r_dwell_cnt;

    logic             w_accept;
    logic             w_wrap;
    logic             w_apply;
    logic [32:0]      w_sum;
    logic [31:0]      w_sat;

    // A falling MSB on the accumulator marks the wrap through zero.
    assign w_wrap   = r_phase_d[31] & ~phase[31];
    assign w_accept = cfg_valid & (r_state == c_S_IDLE) & ~abort;
    assign w_apply  = (r_state == c_S_ARMED) & (~r_sh_sync | w_wrap) & ~abort;

    // Adding two sign-extended operands gives a 33-bit sum. Overflow shows
    // when its top two bits differ, and bit 32 then holds the true sign.
    assign w_sum = {r_freq_add[31], r_freq_add} + {r_sh_step[31], r_sh_step};
    assign w_sat = (w_sum[32] != w_sum[31])
                 ? (w_sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF)
                 : w_sum[31:0];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; abort overrides every transition
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        if (abort) begin
            w_next_state = c_S_IDLE;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (cfg_valid) w_next_state = c_S_ARMED;
                end
                c_S_ARMED: begin
                    if (~r_sh_sync | w_wrap)
                        w_next_state = (r_sh_nsteps == c_CNT_ZERO) ? c_S_DONE : c_S_RAMP;
                end
                c_S_RAMP: begin
                    // "<= 1" guarantees the ramp always exits, even from 0
                    if ((r_dwell_cnt == c_CNT_ZERO) && (r_steps_left <= c_CNT_ONE))
                        w_next_state = c_S_DONE;
                end
                c_S_DONE:  w_next_state = c_S_IDLE;
                default:   w_next_state = c_S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        cfg_ready = (r_state == c_S_IDLE);
        busy      = (r_state != c_S_IDLE);
    end

    assign freq       = r_freq;
    assign freq_add   = r_freq_add;
    assign core_reset = r_core_reset;
    assign done       = r_done;

    // ------------------------------------------------------------------
    // Datapath: shadow regs, tuning words, counters, pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sh_freq    <= '0;
            r_sh_step    <= '0;
            r_sh_nsteps  <= '0;
            r_sh_dwell   <= '0;
            r_sh_sync    <= 1'b0;
            r_sh_rst     <= 1'b0;
            r_phase_d    <= '0;
            r_freq       <= '0;
            r_freq_add   <= '0;
            r_core_reset <= 1'b0;
            r_done       <= 1'b0;
            r_steps_left <= '0;
            r_dwell_cnt  <= '0;
        end else begin
            r_phase_d    <= phase;
            r_core_reset <= 1'b0;
            // done follows the DONE state by one clock, so an abort in
            // DONE can still suppress it
            r_done       <= (r_state == c_S_DONE) & ~abort;

            if (w_accept) begin
                r_sh_freq   <= cfg_freq;
                r_sh_step   <= cfg_step;
                r_sh_nsteps <= cfg_nsteps;
                r_sh_dwell  <= cfg_dwell;
                r_sh_sync   <= cfg_sync;
                r_sh_rst    <= cfg_rst;
            end

            if (abort) begin
                r_freq_add <= '0;
            end else if (w_apply) begin
                r_freq       <= r_sh_freq;
                r_freq_add   <= '0;
                r_core_reset <= r_sh_rst;
                r_steps_left <= r_sh_nsteps;
                r_dwell_cnt  <= r_sh_dwell;
            end else if (r_state == c_S_RAMP) begin
                if (r_dwell_cnt == c_CNT_ZERO) begin
                    r_freq_add   <= w_sat;
                    r_steps_left <= r_steps_left - c_CNT_ONE;
                    r_dwell_cnt  <= r_sh_dwell;
                end else begin
                    r_dwell_cnt  <= r_dwell_cnt - c_CNT_ONE;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dds_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dds_sweep_ctrl
//  Description : Self-checking bench for dds_sweep_ctrl. It drives a table of
//                immediate-apply jobs against a per-cycle expected trace held
//                in a queue, and adds hand-written sequences for phase-wrap
//                apply, abort, busy-time config and async reset.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dds_sweep_ctrl;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [31:0]      cfg_freq;
    logic [31:0]      cfg_step;
    logic [CNT_W-1:0] cfg_nsteps;
    logic [CNT_W-1:0] cfg_dwell;
    logic             cfg_sync;
    logic             cfg_rst;
    logic             abort;
    logic [31:0]      phase;
    logic [31:0]      freq;
    logic [31:0]      freq_add;
    logic             core_reset;
    logic             busy;
    logic             done;

    always #5 clk = ~clk;

    dds_sweep_ctrl #(.CNT_W(CNT_W)) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_freq   (cfg_freq),
        .cfg_step   (cfg_step),
        .cfg_nsteps (cfg_nsteps),
        .cfg_dwell  (cfg_dwell),
        .cfg_sync   (cfg_sync),
        .cfg_rst    (cfg_rst),
        .abort      (abort),
        .phase      (phase),
        .freq       (freq),
        .freq_add   (freq_add),
        .core_reset (core_reset),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        logic [31:0]      freq;
        logic [31:0]      step;
        logic [CNT_W-1:0] nsteps;
        logic [CNT_W-1:0] dwell;
        logic             rst;
        logic [31:0]      exp_fa;   // final freq_add, derived by hand
    } vec_t;

    typedef struct {
        logic [31:0] freq;
        logic [31:0] fa;
        logic        crst;
        logic        busy;
        logic        done;
    } exp_t;

    vec_t        vecs[6];
    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_freq;
    logic [31:0] m_fa;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
        if (s > 64'sd2147483647)       s = 64'sd2147483647;
        else if (s < -64'sd2147483648) s = -64'sd2147483648;
        return s[31:0];
    endfunction

    task automatic drive_job(input logic [31:0] f, input logic [31:0] st,
                             input int n, input int d, input logic sy, input logic rs);
        cfg_valid  = 1'b1;
        cfg_freq   = f;
        cfg_step   = st;
        cfg_nsteps = n[CNT_W-1:0];
        cfg_dwell  = d[CNT_W-1:0];
        cfg_sync   = sy;
        cfg_rst    = rs;
    endtask

    // Immediate-apply job: the expected trace for every cycle from the
    // accept edge (E1) to two cycles past DONE is queued first, then popped
    // and compared edge by edge. Apply happens at E2, increment k lands at
    // E2+k*(d+1), DONE is entered at T, and done shows after E(T+1).
    task automatic run_job(input vec_t v, input int idx);
        int   n, d, t, k;
        exp_t e;
        logic [31:0] acc;
        n   = int'(v.nsteps);
        d   = int'(v.dwell);
        t   = 2 + (d + 1) * n;
        acc = 32'h0;
        k   = 0;
        chk($sformatf("v%0d_ready", idx), {31'b0, cfg_ready}, 32'h1);
        drive_job(v.freq, v.step, n, d, 1'b0, v.rst);
        for (int i = 1; i <= t + 2; i++) begin
            if (i == 1) begin
                e.freq = m_freq;
                e.fa   = m_fa;
            end else begin
                if ((i > 2) && (((i - 2) % (d + 1)) == 0) && (k < n)) begin
                    acc = sat_add(acc, v.step);
                    k++;
                end
                e.freq = v.freq;
                e.fa   = acc;
            end
            e.crst = (i == 2) && v.rst;
            e.busy = (i <= t);
            e.done = (i == t + 1);
            sb_q.push_back(e);
        end
        for (int i = 1; i <= t + 2; i++) begin
            tick();
            if (i == 1) cfg_valid = 1'b0;
            e = sb_q.pop_front();
            chk($sformatf("v%0d_c%0d_freq", idx, i), freq, e.freq);
            chk($sformatf("v%0d_c%0d_fa", idx, i), freq_add, e.fa);
            chk($sformatf("v%0d_c%0d_crst", idx, i), {31'b0, core_reset}, {31'b0, e.crst});
            chk($sformatf("v%0d_c%0d_busy", idx, i), {31'b0, busy}, {31'b0, e.busy});
            chk($sformatf("v%0d_c%0d_done", idx, i), {31'b0, done}, {31'b0, e.done});
        end
        chk($sformatf("v%0d_final_fa", idx), freq_add, v.exp_fa);
        m_freq = v.freq;
        m_fa   = freq_add;
    endtask

    initial begin
        vecs[0] = '{freq: 32'h0147_AEB8, step: 32'h0,         nsteps: 16'd0, dwell: 16'd0, rst: 1'b0, exp_fa: 32'h0};
        vecs[1] = '{freq: 32'h0100_0000, step: 32'h100,       nsteps: 16'd4, dwell: 16'd2, rst: 1'b0, exp_fa: 32'h400};
        vecs[2] = '{freq: 32'h0200_0000, step: 32'h8000_0000, nsteps: 16'd3, dwell: 16'd0, rst: 1'b1, exp_fa: 32'h8000_0000};
        vecs[3] = '{freq: 32'h0210_0000, step: 32'h7FFF_FFFF, nsteps: 16'd3, dwell: 16'd1, rst: 1'b0, exp_fa: 32'h7FFF_FFFF};
        vecs[4] = '{freq: 32'h0220_0000, step: 32'hFFFF_FFFF, nsteps: 16'd2, dwell: 16'd0, rst: 1'b0, exp_fa: 32'hFFFF_FFFE};
        vecs[5] = '{freq: 32'h0230_0000, step: 32'h5,         nsteps: 16'd1, dwell: 16'd0, rst: 1'b1, exp_fa: 32'h5};

        reset_n    = 1'b0;
        cfg_valid  = 1'b0;
        cfg_freq   = '0;
        cfg_step   = '0;
        cfg_nsteps = '0;
        cfg_dwell  = '0;
        cfg_sync   = 1'b0;
        cfg_rst    = 1'b0;
        abort      = 1'b0;
        phase      = 32'h0;
        #2;
        chk("rst_freq", freq, 32'h0);
        chk("rst_fa", freq_add, 32'h0);
        chk("rst_crst", {31'b0, core_reset}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        m_freq = 32'h0;
        m_fa   = 32'h0;

        for (int i = 0; i < 6; i++) begin
            run_job(vecs[i], i);
        end

        // Phase-wrap apply: 0x7FFFFFF0 -> 0xC0000000 is not a wrap,
        // 0xC0000000 -> 0x00000010 is, and apply lands on that edge.
        phase = 32'h7FFF_FFF0;
        tick();
        drive_job(32'h0AAA_0000, 32'h0, 0, 0, 1'b1, 1'b0);
        tick();
        cfg_valid = 1'b0;
        phase = 32'hC000_0000;
        tick();
        chk("sync_hold1_freq", freq, m_freq);
        chk("sync_hold1_busy", {31'b0, busy}, 32'h1);
        tick();
        chk("sync_hold2_freq", freq, m_freq);
        phase = 32'h0000_0010;
        tick();
        chk("sync_apply_freq", freq, 32'h0AAA_0000);
        chk("sync_apply_fa", freq_add, 32'h0);
        tick();
        chk("sync_done", {31'b0, done}, 32'h1);
        tick();
        chk("sync_idle", {31'b0, busy}, 32'h0);
        phase  = 32'h0;
        m_freq = 32'h0AAA_0000;

        // Abort in RAMP after two increments
        drive_job(32'h0300_0000, 32'h20, 5, 1, 1'b0, 1'b0);
        tick();
        cfg_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("abr_pre_fa", freq_add, 32'h40);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abr_busy", {31'b0, busy}, 32'h0);
        chk("abr_fa", freq_add, 32'h0);
        chk("abr_freq", freq, 32'h0300_0000);
        chk("abr_done0", {31'b0, done}, 32'h0);
        tick();
        chk("abr_done1", {31'b0, done}, 32'h0);

        // Abort on the apply edge itself
        drive_job(32'h0400_0000, 32'h1, 2, 0, 1'b0, 1'b1);
        tick();
        cfg_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abrap_freq", freq, 32'h0300_0000);
        chk("abrap_crst", {31'b0, core_reset}, 32'h0);
        chk("abrap_busy", {31'b0, busy}, 32'h0);
        tick();
        chk("abrap_crst1", {31'b0, core_reset}, 32'h0);
        chk("abrap_done", {31'b0, done}, 32'h0);

        // Config offered while busy must be ignored
        drive_job(32'h0500_0000, 32'h10, 3, 0, 1'b0, 1'b0);
        tick();
        cfg_valid = 1'b0;
        tick();
        drive_job(32'h0BAD_0000, 32'h999, 1, 0, 1'b0, 1'b1);
        chk("busy_ready", {31'b0, cfg_ready}, 32'h0);
        tick();
        cfg_valid = 1'b0;
        chk("busy_fa1", freq_add, 32'h10);
        tick();
        chk("busy_fa2", freq_add, 32'h20);
        chk("busy_freq", freq, 32'h0500_0000);

        // Async reset mid-ramp, between clock edges
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_freq", freq, 32'h0);
        chk("arst_fa", freq_add, 32'h0);
        chk("arst_busy", {31'b0, busy}, 32'h0);
        chk("arst_crst", {31'b0, core_reset}, 32'h0);
        chk("arst_done", {31'b0, done}, 32'h0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("arst_done_after", {31'b0, done}, 32'h0);
        chk("arst_ready_after", {31'b0, cfg_ready}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
